// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Packs instruction field bundles into 16-bit ISA words and writes them to
// consecutive imem addresses starting at 0. A load ends on HLT (done), on a
// field range violation (err_code 01) or when a non-HLT word fills the last
// usable address (err_code 10).
//
// Handshake: a bundle transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the FSM state (high exactly while LOAD), never on
// in_valid. The source holds its fields stable until the transfer completes.
module instr_encoder_loader #(
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [3:0]    in_fa,
    input  logic [3:0]    in_fb,
    input  logic [8:0]    in_fc,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [AW:0]   count,
    output logic [1:0]    state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [1:0] E_RANGE = 2'b01;
    localparam logic [1:0] E_FULL  = 2'b10;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [1:0]    state;
    logic [AW-1:0] acc_addr;   // address the next accepted word will occupy
    logic          accept;
    logic          enc_ok;
    logic [15:0]   enc_word;
    logic          is_hlt;

    assign in_ready  = (state == S_LOAD);
    assign busy      = (state == S_LOAD);
    assign state_dbg = state;
    assign accept    = in_valid && in_ready;
    assign is_hlt    = (in_op == 4'hF);

    // Field packing and range check for the bundle currently presented.
    always_comb begin
        enc_ok   = 1'b1;
        enc_word = 16'h0000;
        case (in_op)
            4'hA, 4'hB: begin // LLB, LHB: 8-bit immediate
                enc_ok   = (in_fc[8] == 1'b0);
                enc_word = {in_op, in_fa, in_fc[7:0]};
            end
            4'hC: begin // B: 3-bit condition, 9-bit offset
                enc_ok   = (in_fa[3] == 1'b0);
                enc_word = {in_op, in_fa[2:0], in_fc};
            end
            4'hD: begin // BR: 3-bit condition, register target
                enc_ok   = (in_fa[3] == 1'b0);
                enc_word = {in_op, in_fa[2:0], 1'b0, in_fb, 4'b0000};
            end
            4'hE: begin // PCS
                enc_word = {in_op, in_fa, 8'h00};
            end
            4'hF: begin // HLT
                enc_word = 16'hF000;
            end
            default: begin // ALU, shifts, LW/SW: three 4-bit fields
                enc_ok   = (in_fc[8:4] == 5'd0);
                enc_word = {in_op, in_fa, in_fb, in_fc[3:0]};
            end
        endcase
    end

    // Load FSM, registered write port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc_addr  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 16'h0000;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            count     <= '0;
        end else begin
            mem_we <= 1'b0;
            if (mem_we) begin
                count <= count + 1'b1;
            end
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (!enc_ok) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            err_code <= E_RANGE;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= acc_addr;
                            mem_wdata <= enc_word;
                            if (is_hlt) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else if (acc_addr == LAST_ADDR) begin
                                state    <= S_ERR;
                                err      <= 1'b1;
                                err_code <= E_FULL;
                            end else begin
                                acc_addr <= acc_addr + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // A start is taken only once the final word of the previous
                    // load has been written, so its count is never lost.
                    if (start && !mem_we) begin
                        state    <= S_LOAD;
                        acc_addr <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        err_code <= 2'b00;
                        count    <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: a full-size instance plus a DEPTH=4
// instance sharing the same stimulus, checked against a field-rule model.
module tb_instr_encoder_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [3:0]  in_fa;
    logic [3:0]  in_fb;
    logic [8:0]  in_fc;

    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [8:0]  count;
    logic [1:0]  state_dbg;

    logic        s_in_ready;
    logic        s_mem_we;
    logic [2:0]  s_mem_addr;
    logic [15:0] s_mem_wdata;
    logic        s_busy;
    logic        s_done;
    logic        s_err;
    logic [1:0]  s_err_code;
    logic [3:0]  s_count;
    logic [1:0]  s_state_dbg;

    int errors = 0;
    int checks = 0;

    logic [23:0] wr_q[$];     // observed {addr, data}, full-size instance
    logic [23:0] s_wr_q[$];   // observed {addr, data}, DEPTH=4 instance
    logic [23:0] exp_q[$];    // expected {addr, data}

    instr_encoder_loader #(.AW(8), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_op(in_op), .in_fa(in_fa), .in_fb(in_fb),
        .in_fc(in_fc), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .count(count), .state_dbg(state_dbg)
    );

    instr_encoder_loader #(.AW(3), .DEPTH(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(s_in_ready), .in_op(in_op), .in_fa(in_fa), .in_fb(in_fb),
        .in_fc(in_fc), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .busy(s_busy), .done(s_done), .err(s_err),
        .err_code(s_err_code), .count(s_count), .state_dbg(s_state_dbg)
    );

    // Clock and write monitors
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
        if (s_mem_we) s_wr_q.push_back({5'd0, s_mem_addr, s_mem_wdata});
    end

    // Reference model: word value from the ISA field rules, by arithmetic.
    function automatic void model_enc(input int op, input int fa, input int fb,
                                      input int fc, output bit ok,
                                      output logic [15:0] w);
        int v;
        ok = 1'b1;
        v  = 0;
        if (op <= 9) begin
            ok = (fc < 16);
            v  = op * 4096 + fa * 256 + fb * 16 + fc;
        end else if (op <= 11) begin
            ok = (fc < 256);
            v  = op * 4096 + fa * 256 + fc;
        end else if (op == 12) begin
            ok = (fa < 8);
            v  = op * 4096 + fa * 512 + fc;
        end else if (op == 13) begin
            ok = (fa < 8);
            v  = op * 4096 + fa * 512 + fb * 16;
        end else if (op == 14) begin
            v = op * 4096 + fa * 256;
        end else begin
            v = 61440;
        end
        w = v[15:0];
    endfunction

    // Driver: pulse start, beginning and ending at a falling edge.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Driver: present one bundle until the full-size instance accepts it.
    task automatic drive(input int op, input int fa, input int fb, input int fc,
                         output bit acc);
        in_valid = 1'b1;
        in_op    = op[3:0];
        in_fa    = fa[3:0];
        in_fb    = fb[3:0];
        in_fc    = fc[8:0];
        acc      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                acc = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout op=%0d got=no_accept exp=accept", op);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code, count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code, count});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_not_ready got=%b exp=0", in_ready);
        end
    endtask

    task automatic test_first_word();
        bit acc;
        bit ok;
        logic [15:0] w;
        do_start();
        model_enc(0, 1, 2, 3, ok, w);
        drive(0, 1, 2, 3, acc);
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'd0, w}) begin
            errors++;
            $display("FAIL first_write got=we%b @%h %h exp=we1 @00 %h", mem_we, mem_addr, mem_wdata, w);
        end
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || count !== 9'd1) begin
            errors++;
            $display("FAIL first_single_pulse got=we%b cnt%0d exp=we0 cnt1", mem_we, count);
        end
        drive(15, 0, 0, 0, acc);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit acc;
        bit ok;
        logic [15:0] w;
        int a;
        do_start();
        wr_q.delete();
        exp_q.delete();
        a = 0;
        model_enc(10, 4, 0, 'hA5, ok, w); exp_q.push_back({8'(a), w}); a++;
        model_enc(9, 2, 3, 7, ok, w);     exp_q.push_back({8'(a), w}); a++;
        model_enc(15, 0, 0, 0, ok, w);    exp_q.push_back({8'(a), w});
        drive(10, 4, 0, 'hA5, acc);
        drive(9, 2, 3, 7, acc);
        start = 1'b1;                     // coincides with the HLT accept
        drive(15, 0, 0, 0, acc);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || mem_we !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hlt_done_with_write got=d%b we%b rdy%b exp=d1 we1 rdy0", done, mem_we, in_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (count !== 9'd3 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_status got=cnt%0d busy%b err%b exp=cnt3 busy0 err0", count, busy, err);
        end
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_nwrites got=%0d exp=%0d", wr_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_word%0d got=%h exp=%h", i, wr_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_branch();
        bit acc;
        bit ok;
        logic [15:0] wb;
        logic [15:0] wr;
        do_start();
        wr_q.delete();
        model_enc(12, 5, 0, 'h1FF, ok, wb);
        model_enc(13, 2, 6, 0, ok, wr);
        drive(12, 5, 0, 'h1FF, acc);
        drive(13, 2, 6, 0, acc);
        drive(15, 0, 0, 0, acc);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_q.size() != 3) begin
            errors++;
            $display("FAIL branch_nwrites got=%0d exp=3", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0] !== {8'd0, wb} || wr_q[1] !== {8'd1, wr}) begin
                errors++;
                $display("FAIL branch_words got=%h %h exp=%h %h", wr_q[0], wr_q[1], {8'd0, wb}, {8'd1, wr});
            end
        end
    endtask

    task automatic test_range_err();
        bit acc;
        bit ok;
        logic [15:0] w;
        int op, fa, fb, fc;
        for (int round = 0; round < 2; round++) begin
            do_start();
            wr_q.delete();
            drive(0, 1, 1, 1, acc);
            if (round == 0) begin
                op = 4; fa = 1; fb = 1; fc = 'h010;
            end else begin
                ok = 1'b1;
                while (ok) begin
                    op = $urandom_range(0, 13);
                    fa = $urandom_range(0, 15);
                    fb = $urandom_range(0, 15);
                    fc = $urandom_range(0, 511);
                    model_enc(op, fa, fb, fc, ok, w);
                end
            end
            drive(op, fa, fb, fc, acc);
            checks++;
            if (err !== 1'b1 || err_code !== 2'b01 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL range_err op=%0d got=e%b c%b rdy%b exp=e1 c01 rdy0", op, err, err_code, in_ready);
            end
            repeat (2) @(negedge clk);
            checks++;
            if (count !== 9'd1 || wr_q.size() != 1) begin
                errors++;
                $display("FAIL range_nowrite got=cnt%0d n%0d exp=cnt1 n1", count, wr_q.size());
            end
        end
        do_start();
        checks++;
        if (err !== 1'b0 || err_code !== 2'b00 || count !== 9'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_cleared got=e%b c%b cnt%0d busy%b exp=e0 c00 cnt0 busy1", err, err_code, count, busy);
        end
        wr_q.delete();
        drive(1, 3, 4, 5, acc);
        drive(15, 0, 0, 0, acc);
        @(negedge clk);
        checks++;
        if (wr_q.size() < 1 || wr_q[0][23:16] !== 8'd0) begin
            errors++;
            $display("FAIL restart_addr got=n%0d exp=first write at 00", wr_q.size());
        end
    endtask

    task automatic test_random_stream();
        bit acc;
        bit ok;
        logic [15:0] w;
        int op, fa, fb, fc;
        do_start();
        wr_q.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            ok = 1'b0;
            while (!ok) begin
                op = $urandom_range(0, 14);
                fa = $urandom_range(0, 15);
                fb = $urandom_range(0, 15);
                fc = $urandom_range(0, 511);
                model_enc(op, fa, fb, fc, ok, w);
            end
            exp_q.push_back({8'(i), w});
            drive(op, fa, fb, fc, acc);
        end
        model_enc(15, $urandom_range(0, 15), 0, 0, ok, w);
        exp_q.push_back({8'd20, w});
        drive(15, 0, 0, 0, acc);
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || count !== 9'd21) begin
            errors++;
            $display("FAIL rand_status got=d%b cnt%0d exp=d1 cnt21", done, count);
        end
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_nwrites got=%0d exp=%0d", wr_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_word%0d got=%h exp=%h", i, wr_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_full();
        bit acc;
        bit ok;
        logic [15:0] w;
        int hs;
        // DEPTH=4: five ADDs with in_valid held throughout
        do_start();
        s_wr_q.delete();
        exp_q.delete();
        hs = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_op = 4'd0;
            in_fa = 4'(i);
            in_fb = 4'(i + 1);
            in_fc = 9'(i + 2);
            if (s_in_ready) begin
                model_enc(0, i, i + 1, i + 2, ok, w);
                exp_q.push_back({8'(hs), w});
                hs++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (hs != 4 || s_err !== 1'b1 || s_err_code !== 2'b10 || s_count !== 4'd4) begin
            errors++;
            $display("FAIL full_status got=hs%0d e%b c%b cnt%0d exp=hs4 e1 c10 cnt4", hs, s_err, s_err_code, s_count);
        end
        checks++;
        if (s_wr_q.size() != 4) begin
            errors++;
            $display("FAIL full_nwrites got=%0d exp=4", s_wr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (s_wr_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL full_word%0d got=%h exp=%h", i, s_wr_q[i], exp_q[i]);
                end
            end
        end
        drive(15, 0, 0, 0, acc);   // close the full-size instance's load
        // HLT landing on the last address ends cleanly
        do_start();
        s_wr_q.delete();
        for (int i = 0; i < 3; i++) drive(2, i, 0, 0, acc);
        drive(15, 0, 0, 0, acc);
        repeat (2) @(negedge clk);
        checks++;
        if (s_done !== 1'b1 || s_err !== 1'b0 || s_count !== 4'd4 || s_wr_q.size() != 4) begin
            errors++;
            $display("FAIL hlt_at_last got=d%b e%b cnt%0d n%0d exp=d1 e0 cnt4 n4", s_done, s_err, s_count, s_wr_q.size());
        end else begin
            checks++;
            if (s_wr_q[3] !== {8'd3, 16'hF000}) begin
                errors++;
                $display("FAIL hlt_at_last_word got=%h exp=%h", s_wr_q[3], {8'd3, 16'hF000});
            end
        end
    endtask

    task automatic test_reset_mid_load();
        bit acc;
        do_start();
        do_start();   // start while LOAD is ignored
        checks++;
        if (busy !== 1'b1 || count !== 9'd0) begin
            errors++;
            $display("FAIL start_in_load got=busy%b cnt%0d exp=busy1 cnt0", busy, count);
        end
        wr_q.delete();
        in_valid = 1'b1;
        in_op = 4'd0; in_fa = 4'd1; in_fb = 4'd1; in_fc = 9'd1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code, count} !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0",
                     {in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code, count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (wr_q.size() != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_drops_write got=n%0d busy%b exp=n1 busy0", wr_q.size(), busy);
        end
        do_start();
        wr_q.delete();
        drive(3, 7, 7, 7, acc);
        drive(15, 0, 0, 0, acc);
        @(negedge clk);
        checks++;
        if (wr_q.size() < 1 || wr_q[0][23:16] !== 8'd0) begin
            errors++;
            $display("FAIL reset_restart_addr got=n%0d exp=first write at 00", wr_q.size());
        end
    endtask

    initial begin
        start    = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        in_fa    = '0;
        in_fb    = '0;
        in_fc    = '0;
        rst_n    = 1'b0;
        test_reset();
        test_first_word();
        test_back_to_back();
        test_branch();
        test_range_err();
        test_random_stream();
        test_full();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
